// File: rtl/spc_pkg.sv
// Shared types and default sizing for the serial parity checker.
package spc_pkg;

  localparam int unsigned DEFAULT_FRAME_LEN = 8;
  localparam int unsigned DEFAULT_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } spc_state_e;

endpackage : spc_pkg

// File: rtl/xor_gate_using_mux.sv
// Two-input XOR built from a 2:1 mux: b selects between a and its inverse.
module xor_gate_using_mux (
  input  logic a,
  input  logic b,
  output logic y_c
);

  assign y_c = b ? ~a : a;

endmodule : xor_gate_using_mux

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames followed by one even-parity bit, flags parity
// errors, and keeps a saturating count of errored frames.
module serial_parity_checker
  import spc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int unsigned ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  spc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 parity_acc_q, parity_acc_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic                 out_valid_d;
  logic [FRAME_LEN-1:0] out_data_d;
  logic                 out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 accept_c;
  logic                 parity_xor_c;

  // Running parity and the final check both fold in the current bit.
  xor_gate_using_mux u_parity_xor (
    .a   (parity_acc_q),
    .b   (in_bit),
    .y_c (parity_xor_c)
  );

  // Ready depends only on state so upstream never sees a same-cycle bypass.
  assign in_ready = (state_q != HOLD);
  assign accept_c = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      parity_acc_q <= 1'b0;
      shift_q      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_acc_q <= parity_acc_d;
      shift_q      <= shift_d;
      out_valid    <= out_valid_d;
      out_data     <= out_data_d;
      out_err      <= out_err_d;
      err_cnt      <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    parity_acc_d = parity_acc_q;
    shift_d      = shift_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_err_d    = out_err;
    err_cnt_d    = err_cnt;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          shift_d      = '0;
          shift_d[0]   = in_bit;
          bit_cnt_d    = CNT_W'(1);
          parity_acc_d = in_bit;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (accept_c) begin
          for (int unsigned i = 0; i < FRAME_LEN; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shift_d[i] = in_bit;
          end
          parity_acc_d = parity_xor_c;
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_d == CNT_W'(FRAME_LEN)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (accept_c) begin
          out_data_d  = shift_q;
          out_err_d   = parity_xor_c;
          out_valid_d = 1'b1;
          if (parity_xor_c && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt + ERR_CNT_W'(1);
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule : serial_parity_checker

// File: tb/tb_serial_parity_checker.sv
// Directed self-checking bench for serial_parity_checker (FRAME_LEN=8, ERR_CNT_W=8).
module tb_serial_parity_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [7:0] err_cnt;

  int checks;
  int failures;

  serial_parity_checker #(.FRAME_LEN(8), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one bit for one cycle; returns 1 ns after the accepting edge.
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b c=%0d, want 0 0 0 0", out_valid, out_data, out_err, err_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL good_a5: got v=%b d=%h e=%b c=%0d, want 1 a5 0 0", out_valid, out_data, out_err, err_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL good_a5_drain: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hA5, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_err !== 1'b1 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bad_a5: got v=%b d=%h e=%b c=%0d, want 1 a5 1 1", out_valid, out_data, out_err, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_valid_gaps();
    logic [7:0] d;
    d = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      in_bit = ~d[i];
      @(posedge clk); #1;
    end
    send_bit(1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_err !== 1'b0 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL gaps_3c: got v=%b d=%h e=%b c=%0d, want 1 3c 0 1", out_valid, out_data, out_err, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || out_err !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got v=%b d=%h e=%b rdy=%b, want 1 5a 0 0", i, out_valid, out_data, out_err, in_ready);
      end
      @(posedge clk); #1;
    end
    // Bit offered while HOLD releases must not be taken until IDLE.
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_bypass: got rdy=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL after_hold_01: got v=%b d=%h e=%b, want 1 01 0", out_valid, out_data, out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h e=%b c=%0d rdy=%b, want 0 00 0 0 1", out_valid, out_data, out_err, err_cnt, in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'hFF, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL post_reset_ff: got v=%b d=%h e=%b c=%0d, want 1 ff 0 0", out_valid, out_data, out_err, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 256; n++) begin
      send_frame(8'h00, 1'b1);
      if (n == 254 || n == 255 || n == 256) begin
        checks++;
        if (err_cnt !== ((n > 255) ? 8'd255 : 8'(n))) begin
          failures++;
          $display("FAIL sat_frame%0d: got cnt=%0d want %0d", n, err_cnt, (n > 255) ? 255 : n);
        end
      end
      @(posedge clk); #1;
    end
    send_frame(8'h00, 1'b1);
    checks++;
    if (err_cnt !== 8'd255 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold: got cnt=%0d e=%b want 255 1", err_cnt, out_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_valid_gaps();
    test_back_pressure();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_parity_checker
